// File: rtl/enc_accum_n.sv
// enc_accum_n: priority-encoded press accumulator with seven-segment readout.
// Each press of the request lines adds (index of highest pressed line + 1) to
// the count exactly once, however long the press is held.
// Build option: define ACC_SATURATE_EN to clamp the count at its maximum and
// keep overflow sticky; leave it undefined for wrapping count with a one-cycle
// overflow pulse.
module enc_accum_n #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned W      = 4,
  parameter int unsigned THRESH = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] a,
  input  logic            clr,
  output logic [W-1:0]    count,
  output logic [6:0]      seg,
  output logic            out_m,
  output logic            overflow
);

  localparam int unsigned IDX_W = $clog2(N_IN);
  // Sum is wide enough for both the W+1-bit add and the largest increment.
  localparam int unsigned SUM_W = (W + 1 > IDX_W + 1) ? W + 1 : IDX_W + 1;
  localparam logic [SUM_W-1:0] MAX_CNT = SUM_W'((1 << W) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IN-1:0]  r_a_q;
  logic [W-1:0]     r_count;
  logic             r_overflow;
  logic [IDX_W-1:0] w_idx;
  logic [SUM_W-1:0] w_inc;
  logic [SUM_W-1:0] w_sum;
  logic             w_press;
  logic             w_accum;
  logic [3:0]       w_digit;

  // Input register; all decisions are taken from the registered copy.
  always_ff @(posedge clk) begin
    if (rst) r_a_q <= '0;
    else     r_a_q <= a;
  end

  // MSB-priority encoder; highest set line wins, zero when nothing pressed.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (r_a_q[i]) w_idx = IDX_W'(i);
    end
  end

  assign w_press = |r_a_q;
  assign w_inc   = SUM_W'(w_idx) + SUM_W'(1);
  assign w_sum   = SUM_W'(r_count) + w_inc;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; ACCUM is the single cycle in which a press is added.
  always_comb begin
    w_state_nxt = r_state;
    w_accum     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        w_accum     = 1'b1;
        w_state_nxt = w_press ? S_HELD : S_IDLE;
      end
      S_HELD: begin
        if (!w_press) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef ACC_SATURATE_EN
  // Saturating accumulator; overflow stays set until clr or rst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_accum) begin
      if (w_sum > MAX_CNT) begin
        r_count    <= MAX_CNT[W-1:0];
        r_overflow <= 1'b1;
      end else begin
        r_count    <= w_sum[W-1:0];
      end
    end
  end
`else
  // Wrapping accumulator; overflow pulses alongside the wrapped value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_accum) begin
      r_count    <= w_sum[W-1:0];
      r_overflow <= (w_sum > MAX_CNT);
    end else begin
      r_overflow <= 1'b0;
    end
  end
`endif

  // Hex digit decode of the low nibble, active-low segments {g..a}.
  always_comb begin
    w_digit = 4'(r_count);
    case (w_digit)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  // Threshold compare; a zero threshold is always met.
  generate
    if (THRESH == 0) begin : g_thr_zero
      assign out_m = 1'b1;
    end else begin : g_thr
      assign out_m = (r_count >= W'(THRESH));
    end
  endgenerate

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_enc_accum_n.sv
// Directed testbench for enc_accum_n (default parameters).
module tb_enc_accum_n;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       clr;
  logic [3:0] count;
  logic [6:0] seg;
  logic       out_m;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;

  enc_accum_n #(.N_IN(4), .W(4), .THRESH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .clr      (clr),
    .count    (count),
    .seg      (seg),
    .out_m    (out_m),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; drive and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a   = 4'b0000;
    clr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Full press: held long enough to accumulate, then released back to IDLE.
  task automatic do_press(input logic [3:0] val);
    a = val;
    repeat (4) tick();
    a = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b0;
    a   = 4'b0101;
    repeat (2) tick();
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL reset_count: got %0d expected 0", count); n_fail++;
    end
    n_tests++;
    if (seg !== SEG_0) begin
      $display("FAIL reset_seg: got %b expected %b", seg, SEG_0); n_fail++;
    end
    n_tests++;
    if (out_m !== 1'b0) begin
      $display("FAIL reset_out_m: got %b expected 0", out_m); n_fail++;
    end
    n_tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL reset_overflow: got %b expected 0", overflow); n_fail++;
    end
    rst = 1'b0;
    a   = 4'b0000;
    repeat (3) tick();
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL reset_idle_count: got %0d expected 0", count); n_fail++;
    end
  endtask

  task automatic test_hold();
    a = 4'b0100;
    repeat (2) tick();
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL hold_latency: got %0d expected 0 after 2 edges", count); n_fail++;
    end
    tick();
    n_tests++;
    if (count !== 4'd3) begin
      $display("FAIL hold_first: got %0d expected 3", count); n_fail++;
    end
    repeat (3) tick();
    a = 4'b0000;
    repeat (3) tick();
    n_tests++;
    if (count !== 4'd3) begin
      $display("FAIL hold_once: got %0d expected 3", count); n_fail++;
    end
    do_press(4'b0101);
    n_tests++;
    if (count !== 4'd6) begin
      $display("FAIL hold_priority: got %0d expected 6", count); n_fail++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_press(4'b1000);
    do_press(4'b1000);
    do_press(4'b1000);
    do_press(4'b0010);
    n_tests++;
    if (count !== 4'd14) begin
      $display("FAIL wrap_setup: got %0d expected 14", count); n_fail++;
    end
    a = 4'b0010;
    repeat (3) tick();
`ifdef ACC_SATURATE_EN
    n_tests++;
    if (count !== 4'd15) begin
      $display("FAIL sat_count: got %0d expected 15", count); n_fail++;
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      $display("FAIL sat_overflow: got %b expected 1", overflow); n_fail++;
    end
    tick();
    a = 4'b0000;
    repeat (3) tick();
    n_tests++;
    if (overflow !== 1'b1) begin
      $display("FAIL sat_sticky: got %b expected 1", overflow); n_fail++;
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (overflow !== 1'b0 || count !== 4'd0) begin
      $display("FAIL sat_clr: got ovf=%b count=%0d expected ovf=0 count=0", overflow, count); n_fail++;
    end
`else
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL wrap_count: got %0d expected 0", count); n_fail++;
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      $display("FAIL wrap_overflow: got %b expected 1", overflow); n_fail++;
    end
    tick();
    n_tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL wrap_pulse: got %b expected 0", overflow); n_fail++;
    end
    a = 4'b0000;
    repeat (3) tick();
    n_tests++;
    if (count !== 4'd0 || overflow !== 1'b0) begin
      $display("FAIL wrap_after: got count=%0d ovf=%b expected 0/0", count, overflow); n_fail++;
    end
`endif
  endtask

  task automatic test_clr_collision();
    do_reset();
    do_press(4'b0010);
    n_tests++;
    if (count !== 4'd2) begin
      $display("FAIL clr_setup: got %0d expected 2", count); n_fail++;
    end
    a = 4'b1000;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL clr_priority: got %0d expected 0", count); n_fail++;
    end
    repeat (2) tick();
    a = 4'b0000;
    repeat (3) tick();
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL clr_consumed: got %0d expected 0", count); n_fail++;
    end
    do_press(4'b0001);
    n_tests++;
    if (count !== 4'd1) begin
      $display("FAIL clr_next_press: got %0d expected 1", count); n_fail++;
    end
  endtask

  task automatic test_threshold();
    do_reset();
    do_press(4'b0010);
    n_tests++;
    if (out_m !== 1'b0 || count !== 4'd2) begin
      $display("FAIL thr_below: got out_m=%b count=%0d expected 0/2", out_m, count); n_fail++;
    end
    n_tests++;
    if (seg !== SEG_2) begin
      $display("FAIL thr_seg2: got %b expected %b", seg, SEG_2); n_fail++;
    end
    do_press(4'b0001);
    n_tests++;
    if (out_m !== 1'b1 || count !== 4'd3) begin
      $display("FAIL thr_reach: got out_m=%b count=%0d expected 1/3", out_m, count); n_fail++;
    end
    n_tests++;
    if (seg !== SEG_3) begin
      $display("FAIL thr_seg3: got %b expected %b", seg, SEG_3); n_fail++;
    end
  endtask

  task automatic test_reset_held();
    do_reset();
    a = 4'b0010;
    repeat (4) tick();
    n_tests++;
    if (count !== 4'd2) begin
      $display("FAIL rh_setup: got %0d expected 2", count); n_fail++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL rh_cleared: got %0d expected 0", count); n_fail++;
    end
    repeat (2) tick();
    n_tests++;
    if (count !== 4'd0) begin
      $display("FAIL rh_restart_latency: got %0d expected 0", count); n_fail++;
    end
    tick();
    n_tests++;
    if (count !== 4'd2) begin
      $display("FAIL rh_restart: got %0d expected 2", count); n_fail++;
    end
    repeat (5) tick();
    a = 4'b0000;
    repeat (3) tick();
    n_tests++;
    if (count !== 4'd2) begin
      $display("FAIL rh_single: got %0d expected 2", count); n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    a   = 4'b0000;
    test_reset();
    test_hold();
    test_wrap();
    test_clr_collision();
    test_threshold();
    test_reset_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
